// File: rtl/dm_seq_pkg.sv
// Shared types and helpers for the deformable-mirror SPI frame sequencer.
// Holds the sequencer state set and the frame-RAM address mapping.
package dm_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CAPT,
    LAUNCH,
    WAIT,
    GAP,
    DONE
  } state_e;

  localparam int NUM_CH_DEF = 6;
  localparam int NUM_CS_DEF = 4;

  function automatic int unsigned slot_addr(
    input int unsigned cs,
    input int unsigned ch,
    input int unsigned nch
  );
    return cs * nch + ch;
  endfunction

endpackage

// File: rtl/dm_seq_loader.sv
// Fetch counter, frame-RAM address generation and the SPI word shadow bank.
// The output bank only changes at CAPT so in-flight transfers see stable data.
module dm_seq_loader
  import dm_seq_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int WORD_W = 24,
  parameter int ADDR_W = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fetch_i,
  input  logic                     capt_i,
  input  logic [1:0]               cs_i,
  output logic                     ram_rd_o,
  output logic [ADDR_W-1:0]        ram_addr_o,
  input  logic [WORD_W-1:0]        ram_data_i,
  output logic [NUM_CH*WORD_W-1:0] spi_data_o,
  output logic                     last_o
);

  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [CW-1:0]             cnt_q;
  logic [CW-1:0]             idx_q;
  logic                      rd_q;
  logic [WORD_W-1:0]         shadow_q [NUM_CH];
  logic [NUM_CH*WORD_W-1:0]  spi_q;

  assign last_o     = fetch_i && (cnt_q == CW'(NUM_CH - 1));
  assign ram_rd_o   = fetch_i;
  assign ram_addr_o = fetch_i ?
    ADDR_W'(slot_addr(int'(cs_i), int'(cnt_q), NUM_CH)) : '0;
  assign spi_data_o = spi_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
      rd_q  <= 1'b0;
    end else begin
      cnt_q <= fetch_i ? cnt_q + 1'b1 : '0;
      idx_q <= cnt_q;
      rd_q  <= fetch_i;
    end
  end

  // Read data lags the strobe by one cycle; the last word lands during CAPT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int ch = 0; ch < NUM_CH; ch++) shadow_q[ch] <= '0;
      spi_q <= '0;
    end else begin
      if (rd_q) shadow_q[idx_q] <= ram_data_i;
      if (capt_i) begin
        for (int ch = 0; ch < NUM_CH; ch++)
          spi_q[ch*WORD_W +: WORD_W] <=
            (ch == NUM_CH - 1) ? ram_data_i : shadow_q[ch];
      end
    end
  end

endmodule

// File: rtl/dm_spi_frame_sequencer.sv
// Sequences one DM frame: per chip-select slot, fetch NUM_CH words,
// launch all SPI masters together, wait for completion, then gap.
module dm_spi_frame_sequencer
  import dm_seq_pkg::*;
#(
  parameter int NUM_CH         = NUM_CH_DEF,
  parameter int NUM_CS         = NUM_CS_DEF,
  parameter int WORD_W         = 24,
  parameter int ADDR_W         = 5,
  parameter int GAP_CYCLES     = 8,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     pps,
  input  logic                     pps_en,
  input  logic                     abort,
  input  logic                     clr_status,
  output logic                     ram_rd,
  output logic [ADDR_W-1:0]        ram_addr,
  input  logic [WORD_W-1:0]        ram_data,
  output logic [NUM_CH-1:0]        spi_start,
  output logic [NUM_CH*WORD_W-1:0] spi_data,
  input  logic [NUM_CH-1:0]        spi_busy,
  output logic [1:0]               cs_sel,
  output logic                     cs_active,
  output logic                     busy,
  output logic                     frame_done,
  output logic [15:0]              frame_count,
  output logic                     overrun,
  output logic                     timeout_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + GAP_CYCLES + 1);

  state_e      state_q, state_d;
  logic        pps_q;
  logic [1:0]  cs_q, cs_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [15:0] count_q;
  logic        overrun_q, timeout_q;
  logic        trig, fetch_last, all_idle, wait_exit, timeout_hit, gap_end;

  assign trig      = start | (pps_en & pps & ~pps_q);
  assign all_idle  = ~|spi_busy;
  // The masters raise busy a cycle after launch, so the first WAIT cycle is blind.
  assign wait_exit = (tmr_q != '0) && all_idle;
  assign timeout_hit = (state_q == WAIT) && !wait_exit &&
                       (tmr_q >= TW'(TIMEOUT_CYCLES - 1));
  assign gap_end   = (tmr_q == TW'(GAP_CYCLES - 1));

  dm_seq_loader #(
    .NUM_CH (NUM_CH),
    .WORD_W (WORD_W),
    .ADDR_W (ADDR_W)
  ) u_loader (
    .clk        (clk),
    .rst        (rst),
    .fetch_i    (state_q == FETCH),
    .capt_i     (state_q == CAPT),
    .cs_i       (cs_q),
    .ram_rd_o   (ram_rd),
    .ram_addr_o (ram_addr),
    .ram_data_i (ram_data),
    .spi_data_o (spi_data),
    .last_o     (fetch_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:   if (trig) state_d = FETCH;
        FETCH:  if (fetch_last) state_d = CAPT;
        CAPT:   state_d = LAUNCH;
        LAUNCH: state_d = WAIT;
        WAIT: begin
          if (wait_exit)        state_d = GAP;
          else if (timeout_hit) state_d = IDLE;
        end
        GAP: begin
          if (gap_end)
            state_d = (cs_q == 2'(NUM_CS - 1)) ? DONE : FETCH;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    spi_start   = {NUM_CH{state_q == LAUNCH}};
    cs_active   = (state_q == LAUNCH) || (state_q == WAIT);
    busy        = (state_q != IDLE);
    frame_done  = (state_q == DONE);
    cs_sel      = cs_q;
    frame_count = count_q;
    overrun     = overrun_q;
    timeout_err = timeout_q;
  end

  always_comb begin
    tmr_d = '0;
    if ((state_d == state_q) && ((state_q == WAIT) || (state_q == GAP)))
      tmr_d = tmr_q + 1'b1;
    cs_d = cs_q;
    if (state_d == IDLE)
      cs_d = '0;
    else if ((state_q == GAP) && (state_d == FETCH))
      cs_d = cs_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pps_q     <= 1'b0;
      cs_q      <= '0;
      tmr_q     <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      pps_q <= pps;
      cs_q  <= cs_d;
      tmr_q <= tmr_d;
      if ((state_q == DONE) && !abort) count_q <= count_q + 1'b1;
      if (trig && (state_q != IDLE)) overrun_q <= 1'b1;
      else if (clr_status)           overrun_q <= 1'b0;
      if (timeout_hit && !abort) timeout_q <= 1'b1;
      else if (clr_status)       timeout_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dm_spi_frame_sequencer.sv
// Randomised scoreboard bench for dm_spi_frame_sequencer.
// Frame RAM and SPI masters are modelled; launches are checked against a queue.
module tb_dm_spi_frame_sequencer;

  localparam int NUM_CH = 6;
  localparam int NUM_CS = 4;
  localparam int WORD_W = 24;
  localparam int ADDR_W = 5;
  localparam int DW     = NUM_CH * WORD_W;

  logic              clk = 1'b0;
  logic              rst, start, pps, pps_en, abort, clr_status;
  logic              ram_rd;
  logic [ADDR_W-1:0] ram_addr;
  logic [WORD_W-1:0] ram_data;
  logic [NUM_CH-1:0] spi_start, spi_busy;
  logic [DW-1:0]     spi_data;
  logic [1:0]        cs_sel;
  logic              cs_active, busy, frame_done, overrun, timeout_err;
  logic [15:0]       frame_count;

  dm_spi_frame_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .pps(pps), .pps_en(pps_en),
    .abort(abort), .clr_status(clr_status), .ram_rd(ram_rd),
    .ram_addr(ram_addr), .ram_data(ram_data), .spi_start(spi_start),
    .spi_data(spi_data), .spi_busy(spi_busy), .cs_sel(cs_sel),
    .cs_active(cs_active), .busy(busy), .frame_done(frame_done),
    .frame_count(frame_count), .overrun(overrun), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]    cs;
    logic [DW-1:0] data;
  } exp_t;

  exp_t              expq[$];
  logic [WORD_W-1:0] mem [32];
  int                bc [NUM_CH];
  logic [NUM_CH-1:0] stuck;
  int                busy_len;
  int                total = 0;
  int                bad = 0;
  int                done_cnt = 0;
  int                exp_frames = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_d(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Frame RAM: registered read, data one cycle after the strobe.
  always @(posedge clk) if (ram_rd) ram_data <= mem[ram_addr];

  // SPI masters: busy for busy_len cycles starting the cycle after launch.
  always @(posedge clk) begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (spi_start[ch])   bc[ch] <= busy_len;
      else if (bc[ch] > 0) bc[ch] <= bc[ch] - 1;
    end
  end

  always_comb begin
    spi_busy = '0;
    for (int ch = 0; ch < NUM_CH; ch++)
      spi_busy[ch] = (bc[ch] != 0) || stuck[ch];
  end

  // Reference: slot cs carries RAM word cs*NUM_CH+ch on channel ch.
  task automatic push_frame(input int nslots);
    exp_t e;
    for (int cs = 0; cs < nslots; cs++) begin
      e.cs = 2'(cs);
      for (int ch = 0; ch < NUM_CH; ch++)
        e.data[ch*WORD_W +: WORD_W] = mem[cs*NUM_CH + ch];
      expq.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (spi_start != '0) begin
        chk("start_all_ch", int'(spi_start), (1 << NUM_CH) - 1);
        if (expq.size() == 0) begin
          chk("unexpected_launch", 1, 0);
        end else begin
          exp_t e;
          e = expq.pop_front();
          chk("launch_cs", int'(cs_sel), int'(e.cs));
          chk_d("launch_data", spi_data, e.data);
        end
      end
      if (frame_done) done_cnt++;
    end
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    @(negedge clk);
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_in_budget", int'(busy), 0);
  endtask

  task automatic check_frames(input string nm);
    chk({nm, "_count"}, int'(frame_count), exp_frames);
    chk({nm, "_done"}, done_cnt, exp_frames);
  endtask

  initial begin
    int n;
    logic seen;
    rst = 1'b1; start = 0; pps = 0; pps_en = 0; abort = 0; clr_status = 0;
    stuck = '0; busy_len = 20;
    for (int i = 0; i < NUM_CH; i++) bc[i] = 0;
    for (int i = 0; i < 32; i++) mem[i] = WORD_W'(32'h100 + i);
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_count", int'(frame_count), 0);
    chk("rst_spi_start", int'(spi_start), 0);
    chk_d("rst_spi_data", spi_data, '0);
    chk("rst_ram_rd", int'(ram_rd), 0);
    chk("rst_flags", int'({overrun, timeout_err, cs_active}), 0);
    rst = 1'b0;

    // Nominal frame, fixed RAM pattern
    push_frame(NUM_CS);
    pulse_start();
    n = 1;
    chk("c1_ram_rd", int'(ram_rd), 1);
    chk("c1_ram_addr", int'(ram_addr), 0);
    while (!spi_start[0] && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("first_launch_cycle", n, 8);
    wait_idle(2000);
    exp_frames++;
    check_frames("nominal");

    // PPS edge triggers exactly once while held high
    pps_en = 1'b1;
    for (int i = 0; i < 32; i++) mem[i] = WORD_W'($urandom);
    push_frame(NUM_CS);
    @(negedge clk) pps = 1'b1;
    wait_idle(2000);
    exp_frames++;
    seen = 1'b0;
    repeat (20) @(negedge clk) seen |= busy;
    chk("pps_held_no_retrig", int'(seen), 0);
    check_frames("pps");
    pps_en = 1'b0;
    @(negedge clk) pps = 1'b0;
    @(negedge clk) pps = 1'b1;
    seen = 1'b0;
    repeat (20) @(negedge clk) seen |= busy;
    chk("pps_disabled", int'(seen), 0);
    pps = 1'b0;

    // Overrun: second start mid-frame
    push_frame(NUM_CS);
    pulse_start();
    repeat (48) @(negedge clk);
    pulse_start();
    chk("overrun_set", int'(overrun), 1);
    wait_idle(2000);
    exp_frames++;
    check_frames("overrun");
    @(negedge clk) clr_status = 1'b1;
    @(negedge clk) clr_status = 1'b0;
    chk("overrun_clr", int'(overrun), 0);

    // Randomised frames and busy lengths
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 32; i++) mem[i] = WORD_W'($urandom);
      busy_len = int'($urandom_range(2, 30));
      push_frame(NUM_CS);
      if ($urandom_range(0, 1) == 1) begin
        pulse_start();
      end else begin
        pps_en = 1'b1;
        @(negedge clk) pps = 1'b0;
        @(negedge clk) pps = 1'b1;
      end
      wait_idle(3000);
      exp_frames++;
      pps = 1'b0; pps_en = 1'b0;
    end
    check_frames("random");
    chk("random_q_empty", expq.size(), 0);

    // Timeout: channel C stuck busy
    busy_len = 20;
    stuck = 6'b000100;
    push_frame(1);
    pulse_start();
    n = 0;
    while (!spi_start[0] && n < 40) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (busy && n < 1200) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_window", int'(n >= 1000 && n <= 1002), 1);
    chk("timeout_err_set", int'(timeout_err), 1);
    check_frames("timeout");
    stuck = '0;
    @(negedge clk) clr_status = 1'b1;
    @(negedge clk) clr_status = 1'b0;
    chk("timeout_clr", int'(timeout_err), 0);

    // Abort in GAP of slot 1, then a clean restart
    for (int i = 0; i < 32; i++) mem[i] = WORD_W'($urandom);
    push_frame(2);
    pulse_start();
    n = 0;
    while (!(spi_start[0] && cs_sel == 2'd1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (cs_active && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk) abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    chk("abort_idle", int'(busy), 0);
    chk("abort_cs", int'(cs_sel), 0);
    push_frame(NUM_CS);
    pulse_start();
    chk("restart_addr", int'(ram_addr), 0);
    chk("restart_cs", int'(cs_sel), 0);
    wait_idle(2000);
    exp_frames++;
    check_frames("abort");

    // Asynchronous reset in WAIT
    push_frame(NUM_CS);
    pulse_start();
    repeat (30) @(negedge clk);
    pulse_start();
    n = 0;
    while (!(cs_active && !spi_start[0]) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("pre_rst_overrun", int'(overrun), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_cs_active", int'(cs_active), 0);
    chk("arst_count", int'(frame_count), 0);
    chk("arst_flags", int'({overrun, timeout_err}), 0);
    chk_d("arst_spi_data", spi_data, '0);
    expq.delete();
    @(negedge clk) rst = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
